noise_level_ctrl: RTL

- Parametrised successor to the team's fixed 3-bit-select / 7-bit one-hot noise-level decoder.
- Drives an N_LEVELS-wide one-hot noise/indicator bus from a select input.
- Adds four operating modes (direct, ramp, random, hold), a step prescaler, LFSR-driven random levels, and overload/status flags.
- Sits between the control FSM (which drives s and mode) and the noise/LED output stage.

---
 rtl/noise_pkg.sv | 45 ++++
 rtl/noise_lfsr.sv | 35 +++
 rtl/noise_level_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/noise_pkg.sv
// Shared definitions for the noise-level controller: mode encodings, LFSR tap
// masks and the one-hot output encoder.
package noise_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_RANDOM = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    localparam int          MAX_LEVELS  = 64;
    localparam logic [15:0] LFSR16_TAPS = 16'hB400;

    // Maximal-length Fibonacci tap masks (bit i set = tap at stage i+1).
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        logic [31:0] m;
        case (w)
            32'd3:   m = 32'h0000_0006;
            32'd4:   m = 32'h0000_000C;
            32'd5:   m = 32'h0000_0014;
            32'd6:   m = 32'h0000_0030;
            32'd7:   m = 32'h0000_0060;
            32'd8:   m = 32'h0000_00B8;
            32'd16:  m = {16'h0000, LFSR16_TAPS};
            32'd32:  m = 32'h8020_0003;
            default: m = {16'h0000, LFSR16_TAPS};
        endcase
        return m;
    endfunction

    // One-hot level, or the two-top-bits overload pattern when ovf is set.
    function automatic logic [MAX_LEVELS-1:0] onehot_level(input int unsigned level,
                                                          input logic        ovf,
                                                          input int unsigned n_levels);
        logic [MAX_LEVELS-1:0] v;
        if (ovf) begin
            v = {{(MAX_LEVELS-2){1'b0}}, 2'b11} << (n_levels - 32'd2);
        end else begin
            v = {{(MAX_LEVELS-1){1'b0}}, 1'b1} << level;
        end
        return v;
    endfunction

endpackage

// File: rtl/noise_lfsr.sv
// Fibonacci LFSR that advances on every enabled cycle; a zero seed is forced
// to 1 so the register can never lock up.
module noise_lfsr
    import noise_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter int                OUT_W     = LFSR_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_state
);

    localparam logic [LFSR_W-1:0] SEED_EFF =
        (LFSR_SEED == {LFSR_W{1'b0}}) ? {{(LFSR_W-1){1'b0}}, 1'b1} : LFSR_SEED;
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] r_state;
    logic              w_fb;

    assign w_fb    = ^(r_state & TAPS);
    assign o_state = r_state[OUT_W-1:0];

    // Shift register update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SEED_EFF;
        end else if (i_en) begin
            r_state <= {r_state[LFSR_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/noise_level_ctrl.sv
// Parametrised one-hot noise-level driver with direct, ramp, random and hold
// modes, a step prescaler and overload/status flags.
module noise_level_ctrl
    import noise_pkg::*;
#(
    parameter int                N_LEVELS  = 7,
    parameter int                SEL_W     = 3,
    parameter int                STEP_DIV  = 1000,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    s,
    output logic [N_LEVELS-1:0] noise,
    output logic [SEL_W-1:0]    level,
    output logic                busy,
    output logic                settled,
    output logic                ovf
);

    localparam int               PW         = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX  = PW'(STEP_DIV - 1);
    localparam logic [SEL_W-1:0] TOP_LEVEL  = SEL_W'(N_LEVELS - 1);
    localparam logic [SEL_W-1:0] N_LVL_W    = SEL_W'(N_LEVELS);
    localparam logic [SEL_W:0]   N_EXT      = (SEL_W+1)'(N_LEVELS);

    logic [PW-1:0]       r_presc;
    mode_e               r_mode_q;
    logic [SEL_W-1:0]    r_level;
    logic                r_busy;
    logic                r_settled;
    logic                r_ovf;
    logic [N_LEVELS-1:0] r_noise;

    mode_e                 w_mode;
    logic                  w_mode_chg;
    logic                  w_tick;
    logic                  w_s_ovf;
    logic [SEL_W-1:0]      w_target;
    logic [SEL_W-1:0]      w_rnd;
    logic [SEL_W-1:0]      w_rand_level;
    logic [SEL_W-1:0]      w_ramp_level;
    logic [SEL_W-1:0]      w_level_nx;
    logic                  w_busy_nx;
    logic                  w_settled_nx;
    logic                  w_ovf_nx;
    logic                  w_ovl_pat;
    logic                  w_noise_upd;
    logic [MAX_LEVELS-1:0] w_noise_full;

    noise_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_SEED (LFSR_SEED),
        .OUT_W     (SEL_W)
    ) u_lfsr (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .o_state (w_rnd)
    );

    // A mode change reloads the prescaler and suppresses that cycle's tick.
    assign w_mode       = mode_e'(mode);
    assign w_mode_chg   = (w_mode != r_mode_q);
    assign w_tick       = (r_presc == {PW{1'b0}}) && !w_mode_chg;
    assign w_s_ovf      = ({1'b0, s} >= N_EXT);
    assign w_target     = w_s_ovf ? TOP_LEVEL : s;
    assign w_rand_level = ({1'b0, w_rnd} >= N_EXT) ? (w_rnd - N_LVL_W) : w_rnd;

    // One ramp step toward the target on each tick
    always_comb begin
        w_ramp_level = r_level;
        if (w_tick && (r_level != w_target)) begin
            if (w_target > r_level) begin
                w_ramp_level = r_level + 1'b1;
            end else begin
                w_ramp_level = r_level - 1'b1;
            end
        end else begin
            w_ramp_level = r_level;
        end
    end

    // Next-state selection per operating mode
    always_comb begin
        w_level_nx   = r_level;
        w_busy_nx    = 1'b0;
        w_settled_nx = 1'b0;
        w_ovf_nx     = 1'b0;
        w_ovl_pat    = 1'b0;
        w_noise_upd  = 1'b1;
        case (w_mode)
            MODE_DIRECT: begin
                w_level_nx = w_target;
                w_ovf_nx   = w_s_ovf;
                w_ovl_pat  = w_s_ovf;
            end
            MODE_RAMP: begin
                w_level_nx   = w_ramp_level;
                w_busy_nx    = (w_ramp_level != w_target);
                w_settled_nx = (w_ramp_level != r_level) && (w_ramp_level == w_target);
                w_ovf_nx     = w_s_ovf;
            end
            MODE_RANDOM: begin
                if (w_tick) begin
                    w_level_nx = w_rand_level;
                end else begin
                    w_level_nx = r_level;
                end
            end
            MODE_HOLD: begin
                w_noise_upd = 1'b0;
            end
            default: begin
                w_noise_upd = 1'b0;
            end
        endcase
    end

    assign w_noise_full = onehot_level(32'(w_level_nx), w_ovl_pat, N_LEVELS);

    // State and registered outputs; en=0 freezes everything except settled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= PRESC_MAX;
            r_mode_q  <= MODE_DIRECT;
            r_level   <= {SEL_W{1'b0}};
            r_busy    <= 1'b0;
            r_settled <= 1'b0;
            r_ovf     <= 1'b0;
            r_noise   <= {N_LEVELS{1'b0}};
        end else if (en) begin
            r_presc   <= (w_mode_chg || (r_presc == {PW{1'b0}})) ? PRESC_MAX
                                                                 : (r_presc - 1'b1);
            r_mode_q  <= w_mode;
            r_level   <= w_level_nx;
            r_busy    <= w_busy_nx;
            r_settled <= w_settled_nx;
            r_ovf     <= w_ovf_nx;
            if (w_noise_upd) begin
                r_noise <= w_noise_full[N_LEVELS-1:0];
            end
        end else begin
            r_settled <= 1'b0;
        end
    end

    assign noise   = r_noise;
    assign level   = r_level;
    assign busy    = r_busy;
    assign settled = r_settled;
    assign ovf     = r_ovf;

endmodule
